// File: rtl/console_pattern_gen.sv
// console_pattern_gen
// Text-pattern source for the console character renderer. Watches the pixel
// raster coordinates and produces a codepoint/attribute pair per character
// cell, with per-row, per-cell and fixed sequences, a wrapping codepoint
// range, frame-based scrolling and a generated colour attribute.
// Outputs reflect the cx/cy sampled one clock earlier.
// The attribute colour uses the low nibble of the row and column indices, so
// CX_WIDTH-CELL_W_LOG2 and CY_WIDTH-CELL_H_LOG2 are expected to be >= 4.
module console_pattern_gen #(
    parameter int         CX_WIDTH        = 10,
    parameter int         CY_WIDTH        = 10,
    parameter int         CELL_W_LOG2     = 3,
    parameter int         CELL_H_LOG2     = 4,
    parameter logic [7:0] START_CODEPOINT = 8'h30,
    parameter logic [7:0] END_CODEPOINT   = 8'h7E,
    parameter int         SCROLL_FRAMES   = 30,
    parameter logic [3:0] ATTR_BG         = 4'h0
) (
    input  logic                clk_pixel,
    input  logic                reset_n,
    input  logic [CX_WIDTH-1:0] cx,
    input  logic [CY_WIDTH-1:0] cy,
    input  logic [1:0]          mode,
    input  logic                scroll_en,
    output logic [7:0]          codepoint,
    output logic [7:0]          attribute,
    output logic [15:0]         frame_count
);

    typedef enum logic [1:0] {
        MODE_ROW   = 2'd0,
        MODE_CELL  = 2'd1,
        MODE_FIXED = 2'd2
    } mode_e;

    // Number of codepoints in the wrapping range (up to 256, hence 9 bits).
    localparam logic [8:0]  RANGE          = {1'b0, END_CODEPOINT} - {1'b0, START_CODEPOINT} + 9'd1;
    localparam logic [15:0] SCROLL_DIV_MAX = 16'(SCROLL_FRAMES);

    // Next codepoint in the range, wrapping END back to START.
    function automatic logic [7:0] inc_cp(input logic [7:0] c);
        logic [7:0] r;
        if (c == END_CODEPOINT) begin
            r = START_CODEPOINT;
        end else begin
            r = c + 8'd1;
        end
        return r;
    endfunction

    // History of the previous sample, used for edge-style event detection.
    logic [CY_WIDTH-1:0] prev_row_r;
    logic [CX_WIDTH-1:0] prev_col_r;
    logic                prev_origin_r;
    mode_e               mode_q_r;
    logic [15:0]         scroll_div_r;
    logic [7:0]          scroll_off_r;
    logic [7:0]          row_base_r;

    logic [CY_WIDTH-1:0] row_idx_s;
    logic [CX_WIDTH-1:0] col_idx_s;
    logic                at_origin_s;
    logic                frame_start_s;
    logic                row_chg_s;
    logic                col_chg_s;
    mode_e               mode_in_s;

    mode_e               mode_next_s;
    logic [15:0]         frame_count_next_s;
    logic [15:0]         scroll_step_s;
    logic [15:0]         scroll_div_next_s;
    logic [7:0]          scroll_off_next_s;
    logic [7:0]          load_cp_s;
    logic [7:0]          row_base_next_s;
    logic [7:0]          codepoint_next_s;
    logic [3:0]          fg_sum_s;
    logic [3:0]          fg_s;
    logic [7:0]          attribute_next_s;

    // Cell indices and raster events relative to the previous sample.
    always_comb begin
        row_idx_s     = cy >> CELL_H_LOG2;
        col_idx_s     = cx >> CELL_W_LOG2;
        at_origin_s   = (cx == '0) && (cy == '0);
        frame_start_s = at_origin_s && !prev_origin_r;
        row_chg_s     = (row_idx_s != prev_row_r);
        col_chg_s     = (col_idx_s != prev_col_r);
    end

    // Decode the requested mode; the reserved encoding behaves as ROW.
    always_comb begin
        case (mode)
            2'd1:    mode_in_s = MODE_CELL;
            2'd2:    mode_in_s = MODE_FIXED;
            default: mode_in_s = MODE_ROW;
        endcase
    end

    // Frame bookkeeping, scroll offset and codepoint sequencing.
    always_comb begin
        mode_next_s        = mode_q_r;
        frame_count_next_s = frame_count;
        scroll_step_s      = scroll_div_r + 16'd1;
        scroll_div_next_s  = scroll_div_r;
        scroll_off_next_s  = scroll_off_r;
        load_cp_s          = START_CODEPOINT;
        row_base_next_s    = row_base_r;
        codepoint_next_s   = codepoint;

        if (frame_start_s) begin
            mode_next_s        = mode_in_s;
            frame_count_next_s = frame_count + 16'd1;
            if (scroll_step_s >= SCROLL_DIV_MAX) begin
                scroll_div_next_s = 16'd0;
                // The divider keeps counting while scrolling is disabled;
                // only the offset advance is gated.
                if (scroll_en) begin
                    if (({1'b0, scroll_off_r} + 9'd1) == RANGE) begin
                        scroll_off_next_s = 8'd0;
                    end else begin
                        scroll_off_next_s = scroll_off_r + 8'd1;
                    end
                end else begin
                    scroll_off_next_s = scroll_off_r;
                end
            end else begin
                scroll_div_next_s = scroll_step_s;
            end
            // Offset is always < RANGE, so START + offset stays within range.
            if (scroll_en) begin
                load_cp_s = START_CODEPOINT + scroll_off_next_s;
            end else begin
                load_cp_s = START_CODEPOINT;
            end
            row_base_next_s = load_cp_s;
            if (mode_in_s == MODE_FIXED) begin
                codepoint_next_s = START_CODEPOINT;
            end else begin
                codepoint_next_s = load_cp_s;
            end
        end else begin
            case (mode_q_r)
                MODE_CELL: begin
                    if (row_chg_s) begin
                        row_base_next_s  = inc_cp(row_base_r);
                        codepoint_next_s = inc_cp(row_base_r);
                    end else if (col_chg_s) begin
                        codepoint_next_s = inc_cp(codepoint);
                    end else begin
                        codepoint_next_s = codepoint;
                    end
                end
                MODE_FIXED: begin
                    codepoint_next_s = START_CODEPOINT;
                end
                default: begin
                    if (row_chg_s) begin
                        codepoint_next_s = inc_cp(codepoint);
                    end else begin
                        codepoint_next_s = codepoint;
                    end
                end
            endcase
        end
    end

    // Foreground colour from the cell position, never equal to the background.
    always_comb begin
        fg_sum_s = row_idx_s[3:0] + col_idx_s[3:0];
        if (fg_sum_s == ATTR_BG) begin
            fg_s = ~ATTR_BG;
        end else begin
            fg_s = fg_sum_s;
        end
        attribute_next_s = {ATTR_BG, fg_s};
    end

    // State and output registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            prev_row_r    <= '0;
            prev_col_r    <= '0;
            prev_origin_r <= 1'b1;
            mode_q_r      <= MODE_ROW;
            frame_count   <= 16'd0;
            scroll_div_r  <= 16'd0;
            scroll_off_r  <= 8'd0;
            row_base_r    <= START_CODEPOINT;
            codepoint     <= START_CODEPOINT;
            attribute     <= {ATTR_BG, ~ATTR_BG};
        end else begin
            prev_row_r    <= row_idx_s;
            prev_col_r    <= col_idx_s;
            prev_origin_r <= at_origin_s;
            mode_q_r      <= mode_next_s;
            frame_count   <= frame_count_next_s;
            scroll_div_r  <= scroll_div_next_s;
            scroll_off_r  <= scroll_off_next_s;
            row_base_r    <= row_base_next_s;
            codepoint     <= codepoint_next_s;
            attribute     <= attribute_next_s;
        end
    end

endmodule

// File: tb/tb_console_pattern_gen.sv
// Bench for console_pattern_gen: a short-range, fast-scroll configuration
// driven with a small raster and then random coordinate streams, checked
// every cycle against an index-based model plus hand-computed pins.
module tb_console_pattern_gen;

    localparam logic [7:0] START = 8'h30;
    localparam logic [7:0] ENDC  = 8'h33;
    localparam int         SF    = 2;
    localparam logic [3:0] BG    = 4'h0;
    localparam int         R     = 4;
    localparam int         H     = 24;
    localparam int         V     = 112;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b1;
    logic [9:0] cx        = 10'd0;
    logic [9:0] cy        = 10'd0;
    logic [1:0] mode      = 2'd0;
    logic       scroll_en = 1'b0;
    logic [7:0]  codepoint;
    logic [7:0]  attribute;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: codepoints kept as indices 0..R-1 into the range.
    int m_k, m_rb, m_off, m_div, m_fc, m_mode, m_prev_row, m_prev_col;
    bit m_prev_org;
    logic [7:0]  exp_cp;
    logic [7:0]  exp_attr;
    logic [15:0] exp_fc;

    int wrap_tab[6]   = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31};
    int scroll_tab[7] = '{8'h30, 8'h31, 8'h31, 8'h32, 8'h32, 8'h30, 8'h32};

    console_pattern_gen #(
        .CX_WIDTH(10), .CY_WIDTH(10), .CELL_W_LOG2(3), .CELL_H_LOG2(4),
        .START_CODEPOINT(START), .END_CODEPOINT(ENDC),
        .SCROLL_FRAMES(SF), .ATTR_BG(BG)
    ) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .cy(cy),
        .mode(mode), .scroll_en(scroll_en), .codepoint(codepoint),
        .attribute(attribute), .frame_count(frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] attr_of(input int x, input int y);
        int fg;
        fg = ((y >> 4) + (x >> 3)) % 16;
        if (fg == int'(BG)) fg = 15 - int'(BG);
        return 8'(int'(BG) * 16 + fg);
    endfunction

    task automatic model_reset();
        m_k = 0; m_rb = 0; m_off = 0; m_div = 0; m_fc = 0; m_mode = 0;
        m_prev_row = 0; m_prev_col = 0; m_prev_org = 1'b1;
        exp_cp = START; exp_attr = {BG, ~BG}; exp_fc = 16'd0;
    endtask

    // One clock of the reference behaviour for the current inputs.
    task automatic model_step();
        int x, y, row, col, base;
        bit org, fs, rc, cc;
        x = int'(cx); y = int'(cy);
        row = y >> 4; col = x >> 3;
        org = (x == 0) && (y == 0);
        fs  = org && !m_prev_org;
        rc  = (row != m_prev_row);
        cc  = (col != m_prev_col);
        if (fs) begin
            m_mode = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
            m_fc   = (m_fc + 1) % 65536;
            m_div  = m_div + 1;
            if (m_div == SF) begin
                m_div = 0;
                if (scroll_en) m_off = (m_off + 1) % R;
            end
            base = scroll_en ? m_off : 0;
            m_rb = base;
            m_k  = (m_mode == 2) ? 0 : base;
        end else if (m_mode == 2) begin
            m_k = 0;
        end else if (m_mode == 1) begin
            if (rc) begin
                m_rb = (m_rb + 1) % R;
                m_k  = m_rb;
            end else if (cc) begin
                m_k = (m_k + 1) % R;
            end
        end else if (rc) begin
            m_k = (m_k + 1) % R;
        end
        m_prev_row = row; m_prev_col = col; m_prev_org = org;
        exp_cp   = START + 8'(m_k);
        exp_attr = attr_of(x, y);
        exp_fc   = 16'(m_fc);
    endtask

    task automatic drive(input int x, input int y);
        cx = 10'(x); cy = 10'(y);
        @(posedge clk_pixel);
        model_step();
        @(negedge clk_pixel);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic reset_pulse();
        check_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_async_cp", {8'd0, codepoint}, 16'h0030);
        chk("reset_async_attr", {8'd0, attribute}, 16'h000F);
        chk("reset_async_fc", frame_count, 16'h0000);
        @(negedge clk_pixel);
        model_reset();
        mode = 2'd0;
        reset_n = 1'b1;
        check_en = 1'b1;
    endtask

    task automatic run_frame(input int f);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (f == 3 && y == 100 && x == 0) mode = 2'd2;
                if (f == 4 && y == 60 && x == 0) reset_pulse();
                drive(x, y);
                if (f == 0 && x == H - 1 && y == 15) chk("first_frame_row0", {8'd0, codepoint}, 16'h0030);
                if (f == 0 && x == 0 && y == 16) chk("first_row_inc", {8'd0, codepoint}, 16'h0031);
                if (f == 1 && x == 0 && y == 0) chk("fc_after_origin", frame_count, 16'd1);
                if (f == 1 && x == 0 && (y % 16) == 0 && y < 96)
                    chk("row_wrap", {8'd0, codepoint}, 16'(wrap_tab[y / 16]));
                if (f == 2 && y == 0 && x == 0)  chk("cell_c0", {8'd0, codepoint}, 16'h0030);
                if (f == 2 && y == 0 && x == 8)  chk("cell_c1", {8'd0, codepoint}, 16'h0031);
                if (f == 2 && y == 0 && x == 16) chk("cell_c2", {8'd0, codepoint}, 16'h0032);
                if (f == 2 && y == 16 && x == 0) chk("cell_row1", {8'd0, codepoint}, 16'h0031);
                if (f == 3 && y == 104 && x == 0) chk("mode_switch_row_kept", {8'd0, codepoint}, 16'h0032);
                if (f == 4 && y == 48 && x == 0) chk("fixed_hold", {8'd0, codepoint}, 16'h0030);
                if (f >= 5 && f <= 11 && x == 0 && y == 0)
                    chk("scroll_row0", {8'd0, codepoint}, 16'(scroll_tab[f - 5]));
            end
        end
    endtask

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk_pixel) begin
        if (check_en) begin
            chk("codepoint", {8'd0, codepoint}, {8'd0, exp_cp});
            chk("attribute", {8'd0, attribute}, {8'd0, exp_attr});
            chk("frame_count", frame_count, exp_fc);
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_pixel);
        chk("reset_cp", {8'd0, codepoint}, 16'h0030);
        chk("reset_attr", {8'd0, attribute}, 16'h000F);
        chk("reset_fc", frame_count, 16'h0000);
        reset_n = 1'b1;
        check_en = 1'b1;

        for (int f = 0; f < 12; f++) begin
            case (f)
                0, 1:    begin mode = 2'd0; scroll_en = 1'b0; end
                2:       mode = 2'd1;
                3:       mode = 2'd0;
                5:       scroll_en = 1'b1;
                10:      scroll_en = 1'b0;
                11:      scroll_en = 1'b1;
                default: ;
            endcase
            run_frame(f);
        end

        // Attribute colour at specific cells.
        drive(0, 0);
        chk("attr_r0_c0", {8'd0, attribute}, 16'h000F);
        drive(16, 16);
        chk("attr_r1_c2", {8'd0, attribute}, 16'h0003);
        drive(8, 240);
        chk("attr_r15_c1", {8'd0, attribute}, 16'h000F);

        // Random coordinate streams with stalls, origin hits and mode churn.
        for (int i = 0; i < 6000; i++) begin
            int x, y;
            x = int'(cx); y = int'(cy);
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 19) == 0) begin
                    x = 0; y = 0;
                end else begin
                    x = $urandom_range(0, 80);
                    y = $urandom_range(0, 300);
                end
            end
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) scroll_en = ~scroll_en;
            if (i == 3000) reset_pulse();
            drive(x, y);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/console_pattern_gen.md
# console_pattern_gen

Parametrised text-pattern source for the console character renderer in the HDMI demo tops. It watches the pixel coordinates from the `hdmi` core and produces the `codepoint`/`attribute` pair for each character cell. It supports per-row, per-cell and fixed sequences, a wrapping codepoint range, frame-based scrolling and a generated colour attribute. It replaces the hand-written per-row character counter in each board top.

## Interface
- `CX_WIDTH`, default 10: width of `cx`.
- `CY_WIDTH`, default 10: width of `cy`.
- `CELL_W_LOG2`, default 3: log2 of cell width in pixels.
- `CELL_H_LOG2`, default 4: log2 of cell height in pixels.
- `START_CODEPOINT`, default 8'h30: first codepoint of the range.
- `END_CODEPOINT`, default 8'h7E: last codepoint of the range. Must be ≥ START.
- `SCROLL_FRAMES`, default 30: frames per scroll step. Must be ≥ 1.
- `ATTR_BG`, default 4'h0: background nibble.
- `clk_pixel`, in, 1: pixel clock. Only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cx`, in, CX_WIDTH: current pixel column from `hdmi`.
- `cy`, in, CY_WIDTH: current pixel row from `hdmi`.
- `mode`, in, 2: 0 = ROW, 1 = CELL, 2 = FIXED, 3 = reserved (behaves as ROW).
- `scroll_en`, in, 1: enables the scroll offset.
- `codepoint`, out, 8: character for the current cell. Registered.
- `attribute`, out, 8: {bg[3:0], fg[3:0]}. Registered.
- `frame_count`, out, 16: frames since reset. Wraps.

## Operation
- Derived indices:
  - `row_idx = cy >> CELL_H_LOG2`.
  - `col_idx = cx >> CELL_W_LOG2`.
- Events, all computed from registered previous values:
  - `frame_start`: cx==0 && cy==0, and the previous sample was not (0,0).
  - `row_chg`: row_idx ≠ prev_row_idx.
  - `col_chg`: col_idx ≠ prev_col_idx.
- `inc(c)`: returns START_CODEPOINT if c==END_CODEPOINT, else c+1.
  - Offset addition is modulo the range size R = END−START+1.
- Mode handling:
  - `mode` is latched into `mode_q` only on `frame_start`.
  - A mode change mid-frame takes effect at the next frame.
- On `frame_start`:
  - `frame_count` += 1.
  - Scroll divider += 1. When it reaches SCROLL_FRAMES it clears, and `scroll_off` advances mod R, but only if `scroll_en`=1.
  - When `scroll_en`=0, `scroll_off` holds its value; it is not cleared.
  - `row_base` and `codepoint` load START + (scroll_en ? scroll_off : 0) mod R, using the offset value after this frame's update.
- ROW mode:
  - On `row_chg` (not coincident with `frame_start`): `codepoint` ← inc(`codepoint`).
- CELL mode:
  - On `row_chg`: `row_base` ← inc(`row_base`) and `codepoint` ← inc(`row_base`).
  - Otherwise on `col_chg`: `codepoint` ← inc(`codepoint`).
- FIXED mode:
  - `codepoint` holds START_CODEPOINT. Scroll is ignored.
- Event priority: `frame_start` > `row_chg` > `col_chg`.
- Attribute:
  - fg = (row_idx + col_idx)[3:0].
  - If fg == ATTR_BG, then fg ← ~ATTR_BG.
  - `attribute` = {ATTR_BG, fg}, registered every cycle.

## Timing
- Latency: `codepoint` and `attribute` reflect the cx/cy sampled one clock earlier.
  - Exactly one cycle, in every mode.
- Reset, asynchronous on `reset_n`=0:
  - `codepoint` = START_CODEPOINT.
  - `attribute` = {ATTR_BG, ~ATTR_BG}.
  - `frame_count` = 0.
  - `scroll_off` = 0.
  - Scroll divider = 0.
  - `mode_q` = ROW.
  - `prev_row_idx` and `prev_col_idx` = 0.
  - Previous-sample-at-origin flag = 1, so no `frame_start` fires until the origin is left and re-entered.
- Reset deasserted mid-frame: ROW counting starts from START at the next `row_chg`. Full alignment occurs at the next `frame_start`.
- Codepoint wrap: END → START on the same cycle as the triggering event.
- `frame_count` wraps 16'hFFFF → 0.
- If cx/cy stall (repeated values), no events fire.

## Test plan
- **Reset and first frame.** Release reset, drive a 640x480 raster (800x525 total), mode=ROW, scroll_en=0.
  - codepoint=8'h30 for cy 0–15.
  - 8'h31 appears one clock after cy first reaches 16.
  - frame_count=1 after the second origin crossing.
- **ROW wrap.** START=8'h30, END=8'h33, ROW mode.
  - Rows 0..5 read 30, 31, 32, 33, 30, 31.
- **CELL mode.** Default range.
  - Row 0: cx=0 → 8'h30, cx=8 → 8'h31, cx=16 → 8'h32.
  - Row 1 starts at 8'h31.
- **Scroll.** SCROLL_FRAMES=2, scroll_en=1, ROW mode.
  - Row 0 codepoint reads 30, 31, 31, 32, 32 over successive frames.
  - Deassert scroll_en: row 0 reads 8'h30, and the offset is retained.
- **Mode change mid-frame and async reset.**
  - Switch ROW→FIXED at cy=100: ROW behaviour continues until the next origin, then 8'h30 is held.
  - Pulse reset_n low at cy=200: all outputs take their reset values immediately.
- **Attribute.** ATTR_BG=4'h0.
  - row 0 / col 0 → 8'h0F.
  - row 1 / col 2 → 8'h03.
  - row 15 / col 1 (sum 16 → 0) → 8'h0F.
